// File: rtl/store_buffer_pkg.sv
// Shared types and sizing constants for the posted-write store buffer.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);
  localparam int SB_CNT_W = $clog2(SB_DEPTH + 1);

  // One buffered store: word address (byte offset dropped) plus data.
  typedef struct packed {
    logic [SB_AW-3:0] word;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  // Rebuild a word-aligned byte address from a stored word address.
  function automatic logic [SB_AW-1:0] sbWordToAddr(input logic [SB_AW-3:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-side and memory-side signals of the store buffer, bundled as one interface.
interface store_buffer_if
  import sb_pkg::*;
#(
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  parameter int CNT_W = SB_CNT_W
);

  logic             cpu_memwrite;
  logic [AW-1:0]    cpu_addr;
  logic [DW-1:0]    cpu_wdata;
  logic [AW-1:0]    cpu_raddr;
  logic             cpu_stall;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_ready;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;

  // The buffer itself.
  modport slave (
    input  cpu_memwrite, cpu_addr, cpu_wdata, cpu_raddr, mem_ready,
    output cpu_stall, fwd_hit, fwd_data, mem_we, mem_addr, mem_wdata,
    output count, empty, full
  );

  // Whatever drives the buffer: core plus data memory (or a testbench).
  modport master (
    output cpu_memwrite, cpu_addr, cpu_wdata, cpu_raddr, mem_ready,
    input  cpu_stall, fwd_hit, fwd_data, mem_we, mem_addr, mem_wdata,
    input  count, empty, full
  );

endinterface

// File: rtl/store_buffer_fwd.sv
// Store-to-load forwarding lookup: finds the youngest valid entry whose word
// address matches the load word, searching backwards from the write pointer.
module store_buffer_fwd
  import sb_pkg::*;
#(
  parameter  int DEPTH = SB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  [DEPTH-1:0] valid_i,
  input  sb_entry_t             [DEPTH-1:0] entries_i,
  input  logic                  [PTR_W-1:0] wrPtr_i,
  input  logic                  [SB_AW-3:0] lookupWord_i,
  output logic                              fwdHit_o,
  output logic                  [SB_DW-1:0] fwdData_o
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    fwdHit_o  = 1'b0;
    fwdData_o = '0;
    idx       = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wrPtr_i - PTR_W'(k);
      if (valid_i[idx] && (entries_i[idx].word == lookupWord_i)) begin
        fwdHit_o  = 1'b1;
        fwdData_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core's data-memory write port and the
// data memory. Stores drain in order; loads see the youngest pending store.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave sb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0] entries_q;
  logic      [DEPTH-1:0] valid_q, valid_d;
  logic      [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic      [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic      [CNT_W-1:0] count_q, count_d;

  logic      push, pop, stall, isFull, isEmpty, headValid;
  sb_entry_t headEntry, newEntry;
  logic      unusedBits;

  assign headEntry = entries_q[rdPtr_q];
  assign headValid = valid_q[rdPtr_q];
  assign isEmpty   = (count_q == '0);
  assign isFull    = (count_q == CNT_W'(DEPTH));

  assign pop   = headValid && sb.mem_ready;
  assign stall = sb.cpu_memwrite && isFull && !pop;
  assign push  = sb.cpu_memwrite && !stall;

  assign newEntry.word = sb.cpu_addr[AW-1:2];
  assign newEntry.data = sb.cpu_wdata[DW-1:0];

  // Byte offsets play no part: entries and lookups work on whole words.
  assign unusedBits = ^{sb.cpu_addr[1:0], sb.cpu_raddr[1:0]};

  assign sb.cpu_stall = stall;
  assign sb.mem_we    = headValid;
  assign sb.mem_addr  = sbWordToAddr(headEntry.word);
  assign sb.mem_wdata = headEntry.data;
  assign sb.count     = count_q;
  assign sb.empty     = isEmpty;
  assign sb.full      = isFull;

  // Next-state for pointers, valid bits and occupancy; a push into the slot
  // being popped (full case) must leave that slot valid, so set after clear.
  always_comb begin
    valid_d = valid_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (pop) begin
      valid_d[rdPtr_q] = 1'b0;
      rdPtr_d          = rdPtr_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[wrPtr_q] = 1'b1;
      wrPtr_d          = wrPtr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control state; reset drops every pending store, including the head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: it is only observed through valid bits.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[wrPtr_q] <= newEntry;
    end
  end

  store_buffer_fwd #(.DEPTH(DEPTH)) uFwd (
    .valid_i      (valid_q),
    .entries_i    (entries_q),
    .wrPtr_i      (wrPtr_q),
    .lookupWord_i (sb.cpu_raddr[AW-1:2]),
    .fwdHit_o     (sb.fwd_hit),
    .fwdData_o    (sb.fwd_data)
  );

  aNoPushWhenFull : assert property (@(posedge clk) disable iff (!reset)
    !(push && isFull && !pop));

  aNoPopWhenEmpty : assert property (@(posedge clk) disable iff (!reset)
    !(pop && isEmpty));

  aCountBound : assert property (@(posedge clk) disable iff (!reset)
    count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based reference model predicts
// stall, occupancy and forwarding each cycle, and a separate monitor matches
// every memory write against the scoreboard of accepted stores.
module tb_store_buffer;
  import sb_pkg::*;

  localparam int DEPTH = SB_DEPTH;

  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
  } storeRec_t;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  storeRec_t pend[$];
  storeRec_t expQ[$];

  store_buffer_if sbIf ();

  store_buffer #(.DEPTH(SB_DEPTH), .AW(SB_AW), .DW(SB_DW)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareValue(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Compare the combinational outputs against the model's pending list.
  task automatic checkOutput(input logic expStall, input logic [31:0] raddr);
    int          n;
    logic        expHit;
    logic [31:0] expData;
    n       = pend.size();
    expHit  = 1'b0;
    expData = '0;
    for (int i = 0; i < n; i++) begin
      if (pend[i].word == raddr[31:2]) begin
        expHit  = 1'b1;
        expData = pend[i].data;
      end
    end
    compareValue("cpu_stall", 32'(sbIf.cpu_stall), 32'(expStall));
    compareValue("fwd_hit",   32'(sbIf.fwd_hit),   32'(expHit));
    compareValue("fwd_data",  sbIf.fwd_data,       expData);
    compareValue("count",     32'(sbIf.count),     32'(n));
    compareValue("empty",     32'(sbIf.empty),     32'(n == 0));
    compareValue("full",      32'(sbIf.full),      32'(n == DEPTH));
    compareValue("mem_we",    32'(sbIf.mem_we),    32'(n > 0));
    if (n > 0) begin
      compareValue("mem_addr",  sbIf.mem_addr,  {pend[0].word, 2'b00});
      compareValue("mem_wdata", sbIf.mem_wdata, pend[0].data);
    end
  endtask

  // One clock cycle of core/memory activity, with model update at the edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] raddr,
                               input logic rdy);
    logic      popM, stallM, pushM;
    storeRec_t rec;
    @(negedge clk);
    sbIf.cpu_memwrite = we;
    sbIf.cpu_addr     = addr;
    sbIf.cpu_wdata    = data;
    sbIf.cpu_raddr    = raddr;
    sbIf.mem_ready    = rdy;
    #1;
    popM   = (pend.size() > 0) && rdy;
    stallM = we && (pend.size() == DEPTH) && !popM;
    pushM  = we && !stallM;
    checkOutput(stallM, raddr);
    @(posedge clk);
    if (popM) pend.delete(0);
    if (pushM) begin
      rec.word = addr[31:2];
      rec.data = data;
      pend.push_back(rec);
      expQ.push_back(rec);
    end
  endtask

  task automatic idle(input logic rdy, input logic [31:0] raddr);
    applyStimulus(1'b0, 32'h0, 32'h0, raddr, rdy);
  endtask

  // Monitor: every accepted memory write must be the oldest outstanding store.
  initial begin
    storeRec_t rec;
    forever begin
      @(negedge clk);
      #2;
      if (sbIf.mem_we && sbIf.mem_ready) begin
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpectedWrite: got write to 0x%08h, required none",
                   sbIf.mem_addr);
        end else begin
          rec = expQ.pop_front();
          compareValue("writeAddr", sbIf.mem_addr,  {rec.word, 2'b00});
          compareValue("writeData", sbIf.mem_wdata, rec.data);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    assertCount       = 0;
    failCount         = 0;
    reset             = 1'b0;
    sbIf.cpu_memwrite = 1'b0;
    sbIf.cpu_addr     = '0;
    sbIf.cpu_wdata    = '0;
    sbIf.cpu_raddr    = '0;
    sbIf.mem_ready    = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    compareValue("rstMemWe",  32'(sbIf.mem_we),    32'd0);
    compareValue("rstEmpty",  32'(sbIf.empty),     32'd1);
    compareValue("rstFull",   32'(sbIf.full),      32'd0);
    compareValue("rstFwdHit", 32'(sbIf.fwd_hit),   32'd0);
    compareValue("rstStall",  32'(sbIf.cpu_stall), 32'd0);
    compareValue("rstCount",  32'(sbIf.count),     32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single store, one-cycle latency, then drained
    applyStimulus(1'b1, 32'd36, 32'hFFFF_FFFA, 32'd0, 1'b1);
    idle(1'b1, 32'd36);
    idle(1'b1, 32'd36);

    // Fill while memory is busy, then a stalled fifth store
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 32'd40 + 32'(4 * i), $urandom, 32'd44, 1'b0);
    applyStimulus(1'b1, 32'd56, 32'h0000_0056, 32'd56, 1'b0);
    // Full with simultaneous push and pop: 56 is accepted
    applyStimulus(1'b1, 32'd56, 32'h0000_0056, 32'd56, 1'b1);
    idle(1'b0, 32'd56);
    repeat (5) idle(1'b1, 32'd0);

    // Two stores to the same word: the younger one is forwarded
    applyStimulus(1'b1, 32'd60, 32'h11, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'd61, 32'h22, 32'd62, 1'b0);
    idle(1'b0, 32'd62);
    repeat (3) idle(1'b1, 32'd62);

    // Pointer wrap with a forwarding miss on address 100
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 32'd200 + 32'(4 * i), $urandom, 32'd100, 1'b1);
    repeat (2) idle(1'b1, 32'd100);

    // Randomised traffic over a small word set so forwarding hits are common
    for (int i = 0; i < 300; i++) begin
      a = 32'h1000 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom,
                    32'h1000 + 32'(4 * $urandom_range(0, 6)),
                    1'($urandom_range(0, 2) != 0));
    end
    repeat (6) idle(1'b1, 32'h0);

    // Reset asserted between edges with three stores pending
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'd300 + 32'(4 * i), $urandom, 32'd0, 1'b0);
    @(negedge clk);
    sbIf.cpu_memwrite = 1'b0;
    sbIf.cpu_raddr    = 32'd304;
    sbIf.mem_ready    = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    compareValue("midRstMemWe",  32'(sbIf.mem_we),  32'd0);
    compareValue("midRstCount",  32'(sbIf.count),   32'd0);
    compareValue("midRstEmpty",  32'(sbIf.empty),   32'd1);
    compareValue("midRstFwdHit", 32'(sbIf.fwd_hit), 32'd0);
    pend.delete();
    expQ.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (5) idle(1'b1, 32'd304);

    compareValue("outstandingWrites", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
